// File: rtl/rx_checker_pkg.sv
// Shared types, default parameters and the modular sequence-gap helper for the
// receive-side sequence checker.
package rx_checker_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_t;

   localparam int DEF_N_PKT     = 8;
   localparam int DEF_CTR_W     = 32;
   localparam int DEF_MAX_GAP   = 4;
   localparam int DEF_BAD_LIMIT = 3;
   localparam int DEF_TIMEOUT   = 1_000_000;

   localparam int GAP_FN_W = 32;

   // The low packet-width bits of this difference are the modular gap.
   function automatic logic [GAP_FN_W-1:0] seq_gap(input logic [GAP_FN_W-1:0] data,
                                                   input logic [GAP_FN_W-1:0] expected);
      return data - expected;
   endfunction

endpackage

// File: rtl/rx_sequence_checker_sat_counter.sv
// Saturating statistics counter: adds amt on inc, sticks at all-ones, clear has priority.
module SatCounter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   input  logic [WIDTH-1:0] amt,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] r_q;

   assign w_sum = {1'b0, r_q} + {1'b0, amt};
   assign Q     = r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (clear) begin
         r_q <= '0;
      end else if (inc) begin
         r_q <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/rx_sequence_checker.sv
// Checks decoded packets against an incrementing sequence and keeps link statistics.
// Lost-packet gap classification is built only when RX_CHECKER_GAP_EN is defined.
module rx_sequence_checker
   import rx_checker_pkg::*;
#(
   parameter int N_PKT     = DEF_N_PKT,
   parameter int CTR_W     = DEF_CTR_W,
   parameter int MAX_GAP   = DEF_MAX_GAP,
   parameter int BAD_LIMIT = DEF_BAD_LIMIT,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_PKT-1:0] data_rcv,
   input  logic             avail_rcv,
   input  logic             error_rcv,
   input  logic             clear,
   output logic             read,
   output logic             locked,
   output logic             timed_out,
   output logic [CTR_W-1:0] good_ct,
   output logic [CTR_W-1:0] bad_ct,
   output logic [CTR_W-1:0] lost_ct,
   output logic [CTR_W-1:0] err_ct,
   output logic [CTR_W-1:0] to_ct
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam int RUN_W  = $clog2(BAD_LIMIT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(BAD_LIMIT - 1);
   localparam logic [N_PKT-1:0]  GAP_MAX   = N_PKT'(MAX_GAP);
   localparam logic [N_PKT-1:0]  PKT_ONE   = N_PKT'(1);
   localparam logic [CTR_W-1:0]  CTR_ONE   = CTR_W'(1);
`ifdef RX_CHECKER_GAP_EN
   localparam logic GAP_EN = 1'b1;
`else
   localparam logic GAP_EN = 1'b0;
`endif

   chk_state_t        r_state;
   logic [N_PKT-1:0]  r_expected;
   logic [RUN_W-1:0]  r_bad_run;
   logic [IDLE_W-1:0] r_idle;
   logic              r_read;
   logic              r_timed_out;

   logic              w_acc;
   logic [N_PKT-1:0]  w_gap;
   logic              w_in_lock;
   logic              w_lost_hit;
   logic              w_good;
   logic              w_bad;
   logic              w_timeout;

   assign w_acc      = avail_rcv & r_read;
   assign w_gap      = N_PKT'(seq_gap(GAP_FN_W'(data_rcv), GAP_FN_W'(r_expected)));
   assign w_in_lock  = (r_state == LOCKED) & w_acc;
   assign w_lost_hit = w_in_lock & GAP_EN & (w_gap != '0) & (w_gap <= GAP_MAX);
   assign w_good     = (w_in_lock & (w_gap == '0)) | w_lost_hit;
   assign w_bad      = w_in_lock & ~w_good;
   // An accept in the same cycle always beats the timeout.
   assign w_timeout  = (r_state == LOCKED) & ~w_acc & (r_idle == IDLE_LAST);

   assign read      = r_read;
   assign locked    = (r_state == LOCKED);
   assign timed_out = r_timed_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= HUNT;
         r_expected  <= '0;
         r_bad_run   <= '0;
         r_idle      <= '0;
         r_read      <= 1'b0;
         r_timed_out <= 1'b0;
      end else if (clear) begin
         r_state     <= HUNT;
         r_bad_run   <= '0;
         r_idle      <= '0;
         r_read      <= 1'b0;
         r_timed_out <= 1'b0;
      end else begin
         r_read <= 1'b1;
         if (w_acc) begin
            r_idle <= '0;
            if (r_state == HUNT) begin
               r_expected <= data_rcv + PKT_ONE;
               r_bad_run  <= '0;
               r_state    <= LOCKED;
            end else if (w_good) begin
               r_expected <= data_rcv + PKT_ONE;
               r_bad_run  <= '0;
            end else begin
               // A corrupted packet still consumes one sequence slot.
               r_expected <= r_expected + PKT_ONE;
               if (r_bad_run == RUN_LAST) begin
                  r_state   <= HUNT;
                  r_bad_run <= '0;
               end else begin
                  r_bad_run <= r_bad_run + RUN_W'(1);
               end
            end
         end else if (w_timeout) begin
            r_state     <= HUNT;
            r_idle      <= '0;
            r_timed_out <= 1'b1;
         end else if (r_state == LOCKED) begin
            r_idle <= r_idle + IDLE_W'(1);
         end else begin
            r_idle <= '0;
         end
      end
   end

   SatCounter #(.WIDTH(CTR_W)) u_good_ct (
      .clk(clk), .rst(rst), .clear(clear), .inc(w_good), .amt(CTR_ONE), .Q(good_ct)
   );
   SatCounter #(.WIDTH(CTR_W)) u_bad_ct (
      .clk(clk), .rst(rst), .clear(clear), .inc(w_bad), .amt(CTR_ONE), .Q(bad_ct)
   );
   SatCounter #(.WIDTH(CTR_W)) u_err_ct (
      .clk(clk), .rst(rst), .clear(clear), .inc(error_rcv), .amt(CTR_ONE), .Q(err_ct)
   );
   SatCounter #(.WIDTH(CTR_W)) u_to_ct (
      .clk(clk), .rst(rst), .clear(clear), .inc(w_timeout), .amt(CTR_ONE), .Q(to_ct)
   );

`ifdef RX_CHECKER_GAP_EN
   SatCounter #(.WIDTH(CTR_W)) u_lost_ct (
      .clk(clk), .rst(rst), .clear(clear), .inc(w_lost_hit), .amt(CTR_W'(w_gap)), .Q(lost_ct)
   );
`else
   assign lost_ct = '0;
`endif

endmodule

// File: tb/tb_rx_sequence_checker.sv
// Scoreboard bench for rx_sequence_checker: the driver queues hand-computed expected
// status per accepted packet or probe; a monitor pops and compares after each such edge.
module tb_rx_sequence_checker;

   localparam int N_PKT = 8;
   localparam int CTR_W = 8;

   typedef struct {
      string      name;
      logic       rd;
      logic       lk;
      logic       tof;
      logic [7:0] g, b, l, e, t;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_PKT-1:0] data_rcv;
   logic             avail_rcv;
   logic             error_rcv;
   logic             clear;
   logic             read, locked, timed_out;
   logic [CTR_W-1:0] good_ct, bad_ct, lost_ct, err_ct, to_ct;

   logic             probe;
   exp_t             exp_q[$];
   int               checks = 0;
   int               errors = 0;

   logic             e_rd, e_tof;
   int               e_err, e_to;

   rx_sequence_checker #(
      .N_PKT(N_PKT), .CTR_W(CTR_W), .MAX_GAP(4), .BAD_LIMIT(3), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .data_rcv(data_rcv), .avail_rcv(avail_rcv),
      .error_rcv(error_rcv), .clear(clear), .read(read), .locked(locked),
      .timed_out(timed_out), .good_ct(good_ct), .bad_ct(bad_ct), .lost_ct(lost_ct),
      .err_ct(err_ct), .to_ct(to_ct)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   // Monitor: fires after any edge with an accept or a driver probe.
   initial begin
      exp_t x;
      logic fire;
      forever begin
         @(posedge clk);
         fire = (avail_rcv & read) | probe;
         if (fire) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got output event with empty expectation queue");
            end else begin
               x = exp_q.pop_front();
               if (read !== x.rd || locked !== x.lk || timed_out !== x.tof ||
                   good_ct !== x.g || bad_ct !== x.b || lost_ct !== x.l ||
                   err_ct !== x.e || to_ct !== x.t) begin
                  errors++;
                  $display("FAIL %s: got rd=%0b lk=%0b tof=%0b good=%0d bad=%0d lost=%0d err=%0d to=%0d; want rd=%0b lk=%0b tof=%0b good=%0d bad=%0d lost=%0d err=%0d to=%0d",
                           x.name, read, locked, timed_out, good_ct, bad_ct, lost_ct, err_ct, to_ct,
                           x.rd, x.lk, x.tof, x.g, x.b, x.l, x.e, x.t);
               end else begin
                  $display("ok   %s: lk=%0b good=%0d bad=%0d lost=%0d err=%0d to=%0d",
                           x.name, locked, good_ct, bad_ct, lost_ct, err_ct, to_ct);
               end
            end
         end
      end
   end

   task automatic push(input string nm, input logic lk, input int g, input int b, input int l);
      exp_t x;
      x.name = nm;   x.rd = e_rd;   x.lk = lk;       x.tof = e_tof;
      x.g = 8'(g);   x.b = 8'(b);   x.l = 8'(l);
      x.e = 8'(e_err); x.t = 8'(e_to);
      exp_q.push_back(x);
   endtask

   task automatic sendx(input logic [7:0] d, input logic er, input logic lk,
                        input int g, input int b, input int l, input string nm);
      data_rcv  = d;
      avail_rcv = 1'b1;
      error_rcv = er;
      if (er) e_err++;
      push(nm, lk, g, b, l);
      @(negedge clk);
      avail_rcv = 1'b0;
      error_rcv = 1'b0;
   endtask

   task automatic probe_chk(input logic lk, input int g, input int b, input int l, input string nm);
      avail_rcv = 1'b0;
      push(nm, lk, g, b, l);
      probe = 1'b1;
      @(negedge clk);
      probe = 1'b0;
   endtask

   task automatic do_clear(input string nm);
      e_rd = 1'b0; e_tof = 1'b0; e_err = 0; e_to = 0;
      clear = 1'b1;
      probe_chk(1'b0, 0, 0, 0, nm);
      clear = 1'b0;
      e_rd = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; data_rcv = '0; avail_rcv = 1'b0; error_rcv = 1'b0; clear = 1'b0; probe = 1'b0;
      e_rd = 1'b0; e_tof = 1'b0; e_err = 0; e_to = 0;
      repeat (2) @(negedge clk);
      probe_chk(1'b0, 0, 0, 0, "reset_state");
      rst = 1'b0;
      e_rd = 1'b1;
      probe_chk(1'b0, 0, 0, 0, "read_after_reset");

      // Seed and lock.
      sendx(8'h10, 1'b0, 1'b1, 0, 0, 0, "seed_10");
      sendx(8'h11, 1'b0, 1'b1, 1, 0, 0, "good_11");
      sendx(8'h12, 1'b0, 1'b1, 2, 0, 0, "good_12");

      // Sequence wrap through FF -> 00.
      do_clear("clear_before_wrap");
      sendx(8'hFD, 1'b0, 1'b1, 0, 0, 0, "seed_FD");
      sendx(8'hFE, 1'b0, 1'b1, 1, 0, 0, "wrap_FE");
      sendx(8'hFF, 1'b0, 1'b1, 2, 0, 0, "wrap_FF");
      sendx(8'h00, 1'b0, 1'b1, 3, 0, 0, "wrap_00");

      // Forward gaps, including the MAX_GAP boundary.
      do_clear("clear_before_gap");
      sendx(8'h1F, 1'b0, 1'b1, 0, 0, 0, "seed_1F");
`ifdef RX_CHECKER_GAP_EN
      sendx(8'h23, 1'b0, 1'b1, 1, 0, 3, "gap3_23");
      sendx(8'h24, 1'b0, 1'b1, 2, 0, 3, "after_gap_24");
      sendx(8'h29, 1'b0, 1'b1, 3, 0, 7, "gap4_29");
      sendx(8'h2F, 1'b0, 1'b1, 3, 1, 7, "gap5_2F_bad");
`else
      sendx(8'h23, 1'b0, 1'b1, 0, 1, 0, "gap3_23_bad");
      sendx(8'h21, 1'b0, 1'b1, 1, 1, 0, "exp_21_good");
      sendx(8'h26, 1'b0, 1'b1, 1, 2, 0, "gap4_26_bad");
      sendx(8'h2C, 1'b0, 1'b1, 1, 3, 0, "gap_2C_bad");
`endif

      // Three corrupted packets drop lock, then re-hunt.
      do_clear("clear_before_bad");
      sendx(8'h40, 1'b0, 1'b1, 0, 0, 0, "seed_40");
      sendx(8'h80, 1'b0, 1'b1, 0, 1, 0, "bad1_80");
      sendx(8'h80, 1'b0, 1'b1, 0, 2, 0, "bad2_80");
      sendx(8'h80, 1'b0, 1'b0, 0, 3, 0, "bad3_80_unlock");
      sendx(8'h05, 1'b0, 1'b1, 0, 3, 0, "relock_05");
      sendx(8'h06, 1'b0, 1'b1, 1, 3, 0, "good_06");

      // Timeout after 16 idle cycles while locked.
      repeat (14) @(negedge clk);
      probe_chk(1'b1, 1, 3, 0, "idle15_still_locked");
      e_to = 1; e_tof = 1'b1;
      probe_chk(1'b0, 1, 3, 0, "timeout_16");
      probe_chk(1'b0, 1, 3, 0, "hunt_after_timeout");
      sendx(8'h50, 1'b0, 1'b1, 1, 3, 0, "seed_50_sticky_to");

      // Clear together with a good packet: clear wins.
      clear = 1'b1;
      e_rd = 1'b0; e_tof = 1'b0; e_err = 0; e_to = 0;
      sendx(8'h51, 1'b0, 1'b0, 0, 0, 0, "clear_with_good");
      clear = 1'b0;
      e_rd = 1'b1;
      @(negedge clk);

      // Error pulses and good_ct saturation at all-ones.
      sendx(8'h00, 1'b0, 1'b1, 0, 0, 0, "seed_00");
      for (int i = 1; i <= 260; i++) begin
         logic er;
         er = (i == 1 || i == 3 || i == 5 || i == 7 || i == 9);
         sendx(8'(i), er, 1'b1, (i > 255) ? 255 : i, 0, 0, $sformatf("sat_%0d", i));
      end

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
